// File: rtl/cache_refill_unit_pkg.sv
// Shared types and helpers for the data-cache refill path.
// Used by cache_refill_unit and the cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    RD_REQ,
    RD_WAIT,
    DONE
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_OFF_W = $clog2(WORD_BYTES);

  // Clears the in-block offset bits (word index plus byte offset).
  function automatic logic [31:0] block_align(input logic [31:0] addr,
                                              input int unsigned off_bits);
    return addr & ~((32'd1 << off_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_refill_unit_if.sv
// Bundle of the miss-request, victim-read, fill and memory-bus signals.
// master = refill unit, slave = cache array / controller / memory side.
interface cache_refill_unit_if #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int IDX_W           = $clog2(WORDS_PER_BLOCK)
);
  logic                  miss_req_valid;
  logic                  miss_req_ready;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic                  victim_dirty;
  logic [ADDR_WIDTH-1:0] victim_addr;
  logic [IDX_W-1:0]      victim_word_idx;
  logic [DATA_WIDTH-1:0] victim_rdata;
  logic                  fill_we;
  logic [IDX_W-1:0]      fill_word_idx;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  fill_done;
  logic                  busy;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_rdata;

  modport master (
    input  miss_req_valid, miss_addr, victim_dirty, victim_addr, victim_rdata,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output miss_req_ready, victim_word_idx, fill_we, fill_word_idx, fill_data,
           fill_done, busy, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );

  modport slave (
    output miss_req_valid, miss_addr, victim_dirty, victim_addr, victim_rdata,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  miss_req_ready, victim_word_idx, fill_we, fill_word_idx, fill_data,
           fill_done, busy, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );

endinterface

// File: rtl/cache_refill_unit_addr_gen.sv
// Word index / address generator: (start + cnt) wraps modulo the block size,
// address = block base + index * WORD_BYTES.
module refill_addr_gen
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_W      = 3
) (
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [IDX_W-1:0]      start_idx,
  input  logic [IDX_W-1:0]      cnt,
  output logic [IDX_W-1:0]      word_idx,
  output logic [ADDR_WIDTH-1:0] addr
);

  // Natural IDX_W-bit overflow gives the modulo-block wrap for free.
  assign word_idx = start_idx + cnt;
  assign addr     = base | (ADDR_WIDTH'(word_idx) << WORD_OFF_W);

endmodule

// File: rtl/cache_refill_unit.sv
// Refill / write-back engine: optional dirty-victim write-back, then block fetch.
// Build option: CACHE_REFILL_CRITICAL_WORD_FIRST_EN starts the fetch at the missed word.
module cache_refill_unit
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
  input logic                 clk,
  input logic                 rst,
  cache_refill_unit_if.master bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);
  localparam int unsigned      OFF_W    = IDX_W + WORD_OFF_W;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] miss_base_q, miss_base_d;
  logic [ADDR_WIDTH-1:0] victim_base_q, victim_base_d;
  logic [IDX_W-1:0]      start_q, start_d;
  logic                  fill_we_q, fill_we_d;
  logic [IDX_W-1:0]      fill_idx_q, fill_idx_d;
  logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;

  logic [ADDR_WIDTH-1:0] gen_base, gen_addr;
  logic [IDX_W-1:0]      gen_start, gen_idx;
  logic [IDX_W-1:0]      req_start;

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  assign req_start = bus.miss_addr[OFF_W-1:WORD_OFF_W];
`else
  assign req_start = '0;
`endif

  // Write-back always runs 0..N-1 from the victim base; reads use the latched start.
  assign gen_base  = (state_q == WB_REQ) ? victim_base_q : miss_base_q;
  assign gen_start = (state_q == WB_REQ) ? '0 : start_q;

  refill_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W)
  ) u_addr_gen (
    .base      (gen_base),
    .start_idx (gen_start),
    .cnt       (cnt_q),
    .word_idx  (gen_idx),
    .addr      (gen_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      miss_base_q   <= '0;
      victim_base_q <= '0;
      start_q       <= '0;
      fill_we_q     <= 1'b0;
      fill_idx_q    <= '0;
      fill_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      miss_base_q   <= miss_base_d;
      victim_base_q <= victim_base_d;
      start_q       <= start_d;
      fill_we_q     <= fill_we_d;
      fill_idx_q    <= fill_idx_d;
      fill_data_q   <= fill_data_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    miss_base_d         = miss_base_q;
    victim_base_d       = victim_base_q;
    start_d             = start_q;
    fill_we_d           = 1'b0;
    fill_idx_d          = fill_idx_q;
    fill_data_d         = fill_data_q;
    bus.miss_req_ready  = 1'b0;
    bus.mem_req_valid   = 1'b0;
    bus.mem_req_we      = 1'b0;
    bus.mem_req_addr    = '0;
    bus.mem_req_wdata   = '0;
    bus.victim_word_idx = '0;
    bus.fill_done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.miss_req_ready = 1'b1;
        if (bus.miss_req_valid) begin
          miss_base_d   = ADDR_WIDTH'(block_align(32'(bus.miss_addr), OFF_W));
          victim_base_d = ADDR_WIDTH'(block_align(32'(bus.victim_addr), OFF_W));
          start_d       = req_start;
          cnt_d         = '0;
          state_d       = bus.victim_dirty ? WB_REQ : RD_REQ;
        end
      end
      WB_REQ: begin
        bus.mem_req_valid   = 1'b1;
        bus.mem_req_we      = 1'b1;
        bus.mem_req_addr    = gen_addr;
        bus.mem_req_wdata   = bus.victim_rdata;
        bus.victim_word_idx = cnt_q;
        if (bus.mem_req_ready) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = RD_REQ;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RD_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = gen_addr;
        if (bus.mem_req_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.mem_rsp_valid) begin
          fill_we_d   = 1'b1;
          fill_idx_d  = gen_idx;
          fill_data_d = bus.mem_rsp_rdata;
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      DONE: begin
        // Lines up with the registered final fill_we.
        bus.fill_done = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.fill_we       = fill_we_q;
  assign bus.fill_word_idx = fill_idx_q;
  assign bus.fill_data     = fill_data_q;

endmodule

// File: doc/cache_refill_unit.md
Name: cache_refill_unit

Overview:
- Memory-side refill/write-back engine directly downstream of the data-cache controller in the RV32IM pipeline.
- Accepts one miss request at a time from the cache controller.
- If the victim line is dirty, writes it back word by word to main memory, then fetches the missing block word by word.
- Streams fetched words into the cache data array and signals completion with a one-cycle pulse.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, word width; one memory transaction moves one word.
- WORDS_PER_BLOCK, 8, words per cache line; must be a power of two and ≥2.
- IDX_W, $clog2(WORDS_PER_BLOCK), word-index width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- miss_req_valid  in  1  cache controller requests a refill
- miss_req_ready  out  1  unit idle; request accepted when valid&&ready
- miss_addr  in  ADDR_WIDTH  address that missed (any byte in the block)
- victim_dirty  in  1  victim line must be written back first
- victim_addr  in  ADDR_WIDTH  victim block address
- victim_word_idx  out  IDX_W  word index the cache array must present on victim_rdata
- victim_rdata  in  DATA_WIDTH  victim word, combinational read of the array at victim_word_idx
- fill_we  out  1  write fill_data into the line at fill_word_idx
- fill_word_idx  out  IDX_W  target word of the fill
- fill_data  out  DATA_WIDTH  fetched word
- fill_done  out  1  one-cycle pulse when the block is complete
- busy  out  1  unit not in IDLE
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_we  out  1  1 = write, 0 = read
- mem_req_addr  out  ADDR_WIDTH  word-aligned address
- mem_req_wdata  out  DATA_WIDTH  write data
- mem_rsp_valid  in  1  read data valid
- mem_rsp_rdata  in  DATA_WIDTH  read data

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. On reset: state=IDLE, counter=0. fill_we, fill_done, busy and mem_req_valid are 0; mem_req_we=0; address, index and data outputs are 0.
- Address formation: on acceptance, both addresses are latched block-aligned, with low log2(WORDS_PER_BLOCK)+2 bits cleared. Request address = base + 4*cnt.
- FSM states: IDLE, WB_REQ, RD_REQ, RD_WAIT, DONE.
- IDLE:
  - miss_req_ready=1.
  - On accept: latch both addresses and set cnt=0.
  - Go to WB_REQ if victim_dirty, else RD_REQ.
- WB_REQ:
  - mem_req_valid=1, we=1, addr=victim_base+4*cnt, wdata=victim_rdata, victim_word_idx=cnt.
  - On mem_req_ready: if cnt is last, set cnt=0 and go to RD_REQ; else cnt++.
  - Writes need no response.
- RD_REQ:
  - mem_req_valid=1, we=0, addr=miss_base+4*cnt.
  - On ready, go to RD_WAIT.
- RD_WAIT:
  - On mem_rsp_valid, register fill_we=1, fill_word_idx=cnt, fill_data=mem_rsp_rdata; these are visible the next cycle.
  - If cnt is last, go to DONE; else cnt++ and go to RD_REQ.
- DONE:
  - fill_done=1 for exactly one cycle, coincident with the final fill_we.
  - Return to IDLE.
- Handshake rules:
  - Only one memory transaction is outstanding.
  - Once mem_req_valid rises, valid, we, addr and wdata stay stable until mem_req_ready is sampled high.
  - mem_rsp_valid outside RD_WAIT is ignored.
  - miss_req_valid while busy is not accepted (ready=0).
- Latency: clean miss, memory always ready, response 1 cycle after accept, accept at cycle 0.
  - 2 cycles per word.
  - fill_we at cycles 3,5,...,17.
  - fill_done at cycle 17.
  - A dirty miss adds WORDS_PER_BLOCK cycles.
- Reset mid-operation: return to IDLE immediately and drop mem_req_valid. Words already written remain in the cache; fill_done is never pulsed, so the controller keeps the line invalid.

Optional Feature:
- Macro: CACHE_REFILL_CRITICAL_WORD_FIRST_EN.
- Defined: the read phase starts at the word index of miss_addr and wraps modulo WORDS_PER_BLOCK; still WORDS_PER_BLOCK reads, and fill_word_idx follows the wrapped order. Write-back order is unchanged (0..N-1).
- Undefined: reads always run in order 0..N-1.

Decomposition:
- Package cache_pkg:
  - state enum (IDLE, WB_REQ, RD_REQ, RD_WAIT, DONE)
  - WORD_BYTES=4 constant
  - block_align() function, shared with the cache controller
- Natural sub-module: refill_addr_gen, combinational base + start index + counter → wrapped word index and address.

Test Plan:
- Clean miss 0x0000_1234, victim_dirty=0, ready=1, rsp +1 cycle → reads 0x1220..0x123C in order; fill_word_idx 0..7 with data 0xA0..0xA7; fill_done only at cycle 17.
- Dirty miss 0x0000_1240, victim 0x0000_8000 with data 0xD0..0xD7 → 8 writes 0x8000..0x801C carrying 0xD0..0xD7; then 8 reads 0x1240..0x125C; no fill_we during write-back.
- mem_req_ready held low 3 cycles on each request → mem_req_valid/addr/wdata held stable; order and counts unchanged; fill_done delayed accordingly.
- rst asserted in RD_WAIT after 3 fills → next cycle all outputs 0, busy=0; no fill_done; a new miss 0x2000 completes normally.
- CACHE_REFILL_CRITICAL_WORD_FIRST_EN defined, miss 0x0000_123C → read addresses 0x123C, 0x1220, 0x1224..0x1238; fill_word_idx 7,0..6.
- miss_req_valid held high during refill → miss_req_ready=0, no second accept; spurious mem_rsp_valid in IDLE → no fill_we.
